// File: rtl/cache_trace_driver.sv
// rtl/cache_trace_driver.sv - trace-ROM driven cache request generator with load checking and stall watchdog
// Walks a sync trace ROM of {op, addr, data} words and issues one cache request per memory op.
module cache_trace_driver #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 16,
  parameter int OP_W    = 4,
  parameter int WDOG_W  = 16,
  parameter int TRACE_W = OP_W + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    tr_addr,
  input  logic [TRACE_W-1:0] tr_data,
  output logic               req_cs,
  output logic               req_rw,
  output logic               req_flush,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  input  logic               res_hold,
  input  logic [DATA_W-1:0]  res_rdata,
  output logic               busy,
  output logic               done,
  output logic               err_wdog,
  output logic [PC_W-1:0]    op_cnt,
  output logic [15:0]        mism_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DELAY, S_DONE} state_t;

  localparam logic [OP_W-1:0]   OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0]   OP_FLUSH = OP_W'(2);
  localparam logic [OP_W-1:0]   OP_LDCHK = OP_W'(3);
  localparam logic [OP_W-1:0]   OP_WAIT  = OP_W'(4);
  localparam logic [OP_W-1:0]   OP_HALT  = OP_W'(5);
  localparam logic [WDOG_W-1:0] WD_TRIP  = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic              last_op;
  logic [OP_W-1:0]   op;
  logic [WDOG_W-1:0] wait_cnt;
  logic [WDOG_W-1:0] wd_cnt;

  logic [OP_W-1:0]   f_op;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic [WDOG_W-1:0] f_wait;
  logic              pc_last;
  state_t            after_op;

  assign f_op     = tr_data[OP_W+ADDR_W+DATA_W-1 -: OP_W];
  assign f_addr   = tr_data[DATA_W +: ADDR_W];
  assign f_data   = tr_data[DATA_W-1:0];
  assign f_wait   = f_data[WDOG_W-1:0];
  assign pc_last  = (pc == {PC_W{1'b1}});
  assign after_op = last_op ? S_DONE : S_FETCH;

  assign tr_addr  = pc;
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      last_op   <= 1'b0;
      op        <= '0;
      wait_cnt  <= '0;
      wd_cnt    <= '0;
      req_cs    <= 1'b0;
      req_rw    <= 1'b0;
      req_flush <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      err_wdog  <= 1'b0;
      op_cnt    <= '0;
      mism_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc       <= '0;
            op_cnt   <= '0;
            mism_cnt <= '0;
            err_wdog <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op        <= f_op;
          req_addr  <= f_addr;
          req_wdata <= f_data;
          last_op   <= pc_last;
          wd_cnt    <= '0;
          if (!pc_last) pc <= pc + PC_W'(1);
          if (f_op <= OP_LDCHK) begin
            req_cs    <= 1'b1;
            req_rw    <= (f_op == OP_STORE);
            req_flush <= (f_op == OP_FLUSH);
            state     <= S_EXEC;
          end else if (f_op == OP_WAIT) begin
            // The WAIT's own FETCH and DECODE count toward its idle time, so DELAY covers the rest.
            if (f_wait > WDOG_W'(2)) begin
              wait_cnt <= f_wait - WDOG_W'(3);
              state    <= S_DELAY;
            end else begin
              state <= pc_last ? S_DONE : S_FETCH;
            end
          end else if (f_op == OP_HALT) begin
            state <= S_DONE;
          end else begin
            state <= pc_last ? S_DONE : S_FETCH;
          end
        end
        S_EXEC: begin
          if (!res_hold) begin
            req_cs    <= 1'b0;
            req_rw    <= 1'b0;
            req_flush <= 1'b0;
            op_cnt    <= op_cnt + PC_W'(1);
            if ((op == OP_LDCHK) && (res_rdata != req_wdata) && (mism_cnt != 16'hFFFF))
              mism_cnt <= mism_cnt + 16'd1;
            state <= after_op;
          end else if (wd_cnt == WD_TRIP) begin
            // Stalled op is abandoned without being counted.
            req_cs    <= 1'b0;
            req_rw    <= 1'b0;
            req_flush <= 1'b0;
            err_wdog  <= 1'b1;
            state     <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + WDOG_W'(1);
          end
        end
        S_DELAY: begin
          if (wait_cnt == '0) state <= after_op;
          else wait_cnt <= wait_cnt - WDOG_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
